// File: rtl/plab2_proc_muldiv_unit.sv
// plab2_proc_muldiv_unit
//   Iterative 32-bit multiply/divide responder for the processor X stage.
//   It accepts one operation over a val/rdy request port and runs 32
//   iterations, one per cycle. It then holds the registered result on a
//   val/rdy response port until the response is taken.
//
// Ports
//   clk       clock
//   reset     asynchronous active-low reset
//   req_val   request valid
//   req_rdy   request ready (registered, depends on state only)
//   req_msg   {fn[66:64], a[63:32], b[31:0]}
//             fn: 0 mul, 1 div, 2 divu, 3 rem, 4 remu, 5-7 reserved (result 0)
//   resp_val  response valid (registered, depends on state only)
//   resp_rdy  response ready
//   resp_msg  32-bit result, stable while resp_val && !resp_rdy
module plab2_proc_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [66:0] req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_fn;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  // Shared operand registers:
  //   mul : r_opa = shifted multiplicand, r_opb = shifted multiplier, r_acc = product
  //   div : r_opa = dividend / quotient,  r_opb = divisor,            r_acc = remainder
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_acc;
  logic [31:0] r_result;
  logic        r_req_rdy;
  logic        r_resp_val;

  // Request decode
  logic [2:0]  w_fn;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_req_signed;
  logic        w_req_is_div;
  logic [31:0] w_a_ld;
  logic [31:0] w_b_ld;

  assign w_fn         = req_msg[66:64];
  assign w_a          = req_msg[63:32];
  assign w_b          = req_msg[31:0];
  assign w_req_signed = (w_fn == FN_DIV) || (w_fn == FN_REM);
  assign w_req_is_div = (w_fn == FN_DIV) || (w_fn == FN_DIVU) ||
                        (w_fn == FN_REM) || (w_fn == FN_REMU);
  assign w_a_ld       = (w_req_signed && w_a[31]) ? (32'd0 - w_a) : w_a;
  assign w_b_ld       = (w_req_signed && w_b[31]) ? (32'd0 - w_b) : w_b;

  // One iteration of either algorithm
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic        w_ge;
  logic [31:0] w_acc_nxt;
  logic [31:0] w_opa_nxt;
  logic [31:0] w_opb_nxt;

  assign w_rem_sh  = {r_acc, r_opa[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};

  always_comb begin
    w_acc_nxt = r_acc;
    w_opa_nxt = r_opa;
    w_opb_nxt = r_opb;
    if (r_is_div) begin
      // Remainder stays below the divisor, so it always fits in 32 bits.
      w_acc_nxt = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
      w_opa_nxt = {r_opa[30:0], w_ge};
    end else begin
      w_acc_nxt = r_opb[0] ? (r_acc + r_opa) : r_acc;
      w_opa_nxt = {r_opa[30:0], 1'b0};
      w_opb_nxt = {1'b0, r_opb[31:1]};
    end
  end

  // Final result, taken from the last iteration's outputs with sign fixup.
  // A zero divisor makes every quotient bit 1 and leaves |a| in the
  // remainder. Quotient negation is suppressed at accept for that case,
  // so div returns all ones. The remainder fixup turns |a| back into a,
  // so rem returns the dividend unchanged.
  logic [31:0] w_result;

  always_comb begin
    w_result = 32'd0;
    case (r_fn)
      FN_MUL:          w_result = w_acc_nxt;
      FN_DIV, FN_DIVU: w_result = r_neg_q ? (32'd0 - w_opa_nxt) : w_opa_nxt;
      FN_REM, FN_REMU: w_result = r_neg_r ? (32'd0 - w_acc_nxt) : w_acc_nxt;
      default:         w_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_fn       <= 3'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_opa      <= 32'd0;
      r_opb      <= 32'd0;
      r_acc      <= 32'd0;
      r_result   <= 32'd0;
      r_req_rdy  <= 1'b1;
      r_resp_val <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_val && r_req_rdy) begin
            r_fn      <= w_fn;
            r_is_div  <= w_req_is_div;
            r_neg_q   <= w_req_signed && (w_a[31] ^ w_b[31]) && (w_b != 32'd0);
            r_neg_r   <= w_req_signed && w_a[31];
            r_opa     <= w_req_is_div ? w_a_ld : w_a;
            r_opb     <= w_req_is_div ? w_b_ld : w_b;
            r_acc     <= 32'd0;
            r_cnt     <= 5'd0;
            r_state   <= CALC;
            r_req_rdy <= 1'b0;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_opa <= w_opa_nxt;
          r_opb <= w_opb_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result   <= w_result;
            r_resp_val <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (r_resp_val && resp_rdy) begin
            r_resp_val <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_req_rdy  <= 1'b1;
          r_resp_val <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy  = r_req_rdy;
  assign resp_val = r_resp_val;
  assign resp_msg = r_result;

endmodule

// File: tb/tb_plab2_proc_muldiv_unit.sv
module tb_plab2_proc_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [66:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int n_chk = 0;
  int n_fail = 0;

  plab2_proc_muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts cycles (sampled #1 after each posedge) until resp_val; bounded.
  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_val && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    chk({tag, "_req_rdy"}, {31'd0, req_rdy}, 32'd1);
    req_val  = 1'b1;
    req_msg  = {fn, a, b};
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    // Garbage outside the accept cycle must not disturb the operation.
    req_msg = {3'd0, $urandom, $urandom};
    wait_resp(cyc);
    chk({tag, "_lat"}, cyc, 32'd32);
    chk({tag, "_res"}, resp_msg, exp);
    @(posedge clk); #1;
    chk({tag, "_post_hs"}, {30'd0, req_rdy, resp_val}, 32'd2);
  endtask

  initial begin
    int cyc;
    int seen;
    reset    = 1'b0;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;
    #12;
    chk("rst_outs", {req_rdy, resp_val, resp_msg[29:0]}, {2'b10, 30'd0});
    chk("rst_msg", resp_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mul
    run_op("mul_3xm4",   3'd0, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFF4);
    run_op("mul_ffff",   3'd0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001);
    // signed division
    run_op("div_m7_2",   3'd1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    run_op("rem_m7_2",   3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    run_op("div_100_m7", 3'd1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2);
    run_op("rem_100_m7", 3'd3, 32'h00000064, 32'hFFFFFFF9, 32'h00000002);
    run_op("div_ovf",    3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    // unsigned division
    run_op("divu",       3'd2, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF);
    run_op("remu",       3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F);
    // divide by zero
    run_op("div_z",      3'd1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF);
    run_op("divu_z",     3'd2, 32'h12345678, 32'h00000000, 32'hFFFFFFFF);
    run_op("rem_z",      3'd3, 32'h12345678, 32'h00000000, 32'h12345678);
    run_op("remu_z",     3'd4, 32'h12345678, 32'h00000000, 32'h12345678);
    run_op("rem_z_neg",  3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
    // reserved fn
    run_op("rsvd",       3'd5, 32'h00000006, 32'h00000007, 32'h00000000);

    // Backpressure: 6*7 held 5 cycles, with a pending 2*3 request behind it
    @(negedge clk);
    req_val  = 1'b1;
    req_msg  = {3'd0, 32'd6, 32'd7};
    resp_rdy = 1'b0;
    @(posedge clk); #1;
    req_msg = {3'd0, 32'd2, 32'd3};
    wait_resp(cyc);
    chk("bp_lat", cyc, 32'd32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_msg", resp_msg, 32'h0000002A);
      chk("bp_vr", {30'd0, resp_val, req_rdy}, 32'd2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_post_hs", {30'd0, req_rdy, resp_val}, 32'd2);
    @(posedge clk); #1;
    req_val = 1'b0;
    chk("bp_accept", {31'd0, req_rdy}, 32'd0);
    wait_resp(cyc);
    chk("bp2_lat", cyc, 32'd32);
    chk("bp2_res", resp_msg, 32'h00000006);
    @(posedge clk); #1;
    chk("bp2_post_hs", {30'd0, req_rdy, resp_val}, 32'd2);

    // Reset 10 cycles into a div
    @(negedge clk);
    req_val = 1'b1;
    req_msg = {3'd1, 32'd100, 32'd7};
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid", {30'd0, req_rdy, resp_val}, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_val) seen = 1;
    end
    chk("rst_noresp", seen, 32'd0);
    run_op("mul_after_rst", 3'd0, 32'd2, 32'd3, 32'h00000006);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
